// File: rtl/spi_dac_pkg.sv
// Shared types and constants for the SPI DAC receiver.
// Frame layout: [FRAME_BITS-1 -: CTRL_W] control, [DATA_W-1:0] sample.
package spi_dac_pkg;

  localparam int FRAME_BITS_DEF = 16;
  localparam int CTRL_W_DEF     = 4;
  localparam int DATA_W_DEF     = 12;

  localparam logic [3:0] CTRL_WRITE        = 4'h0;
  localparam logic [3:0] CTRL_UPDATE       = 4'h1;
  localparam logic [3:0] CTRL_WRITE_UPDATE = 4'h3;
  localparam logic [3:0] CTRL_POWER_DOWN   = 4'hF;

  typedef enum logic [1:0] {
    ST_ARM,
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus previous-value register.
// Provides the synchronized level and single-cycle rise/fall strobes.
module sync_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  // Next values of the synchronizer chain
  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Synchronizer and edge-history registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;
  assign fall  = ~s2_q & prev_q;

endmodule

// File: rtl/spi_dac_receiver.sv
// Oversampled SPI slave modelling the DAC input of the DDS link.
// Deserializes frames, flags malformed ones and counts good ones.
module spi_dac_receiver
  import spi_dac_pkg::*;
#(
  parameter int   FRAME_BITS     = FRAME_BITS_DEF,
  parameter int   DATA_W         = DATA_W_DEF,
  parameter int   CTRL_W         = CTRL_W_DEF,
  parameter bit   SAMPLE_ON_FALL = 1'b1,
  parameter logic SCK_IDLE       = 1'b0
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic [DATA_W-1:0] sample_data,
  output logic [CTRL_W-1:0] sample_ctrl,
  output logic              sample_valid,
  output logic              frame_error,
  output logic [15:0]       frame_count,
  output logic              busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic cap;
  logic unused_edges;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]            arm_q, arm_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [15:0]           count_q, count_d;

  sync_edge_detect #(.RST_VAL(1'b1)) u_cs (
    .clk   (sysclk),
    .reset (reset),
    .din   (spi_cs),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge_detect #(.RST_VAL(SCK_IDLE)) u_sck (
    .clk   (sysclk),
    .reset (reset),
    .din   (spi_sck),
    .level (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge_detect #(.RST_VAL(1'b0)) u_mosi (
    .clk   (sysclk),
    .reset (reset),
    .din   (spi_mosi),
    .level (mosi_lvl),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  assign unused_edges = ^{sck_lvl, mosi_rise, mosi_fall};
  assign cap = SAMPLE_ON_FALL ? sck_fall : sck_rise;

  // Frame FSM: next state, shifter, counters and output strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    arm_d   = arm_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    count_d = count_q;
    unique case (state_q)
      ST_ARM: begin
        // cs sync chain resets high; let the pin value
        // flush through before trusting the level
        if (arm_q != 2'd2) begin
          arm_d = arm_q + 2'd1;
        end else if (cs_lvl) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_DONE;
        end else if (cap) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_lvl};
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (cnt_q == CNT_FULL) begin
          data_d  = shreg_q[DATA_W-1:0];
          ctrl_d  = shreg_q[FRAME_BITS-1 -: CTRL_W];
          valid_d = 1'b1;
          count_d = count_q + 16'd1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= ST_ARM;
      cnt_q   <= '0;
      shreg_q <= '0;
      arm_q   <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      arm_q   <= arm_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_ctrl  = ctrl_q;
  assign sample_valid = valid_q;
  assign frame_error  = err_q;
  assign frame_count  = count_q;
  assign busy         = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Scoreboard bench for spi_dac_receiver.
// Driver pushes expected frame outcomes; monitor pops on each strobe.
module tb_spi_dac_receiver;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        spi_sck;
  logic        spi_cs;
  logic        spi_mosi;
  logic [11:0] sample_data;
  logic [3:0]  sample_ctrl;
  logic        sample_valid;
  logic        frame_error;
  logic [15:0] frame_count;
  logic        busy;

  spi_dac_receiver dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .spi_sck      (spi_sck),
    .spi_cs       (spi_cs),
    .spi_mosi     (spi_mosi),
    .sample_data  (sample_data),
    .sample_ctrl  (sample_ctrl),
    .sample_valid (sample_valid),
    .frame_error  (frame_error),
    .frame_count  (frame_count),
    .busy         (busy)
  );

  always #5 sysclk = ~sysclk;

  int unsigned cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [11:0] data;
    logic [3:0]  ctrl;
    logic [15:0] cnt;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] m_data;
  logic [3:0]  m_ctrl;
  logic [15:0] m_count;

  // Monitor: every strobe must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge sysclk);
      #1;
      if (sample_valid || frame_error) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%h at cyc %0d, required no pulse",
                   sample_valid, frame_error, sample_data, cyc);
        end else begin
          e = sb.pop_front();
          if (sample_valid !== !e.err || frame_error !== e.err ||
              sample_data !== e.data || sample_ctrl !== e.ctrl ||
              frame_count !== e.cnt || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL frame_result: got v=%0b e=%0b d=%h c=%h n=%0d cyc=%0d, required v=%0b e=%0b d=%h c=%h n=%0d cyc=%0d",
                     sample_valid, frame_error, sample_data, sample_ctrl,
                     frame_count, cyc, !e.err, e.err, e.data, e.ctrl,
                     e.cnt, e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_ctrl  = '0;
    m_count = '0;
    sb.delete();
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic clock_bits(input logic [31:0] word, input int nbits,
                            input int half);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = word[i];
      spi_sck  = 1'b1;
      wait_n(half);
      spi_sck  = 1'b0;
      wait_n(half);
    end
  endtask

  // One cs-framed transfer; expectation comes from the frame length rule
  task automatic send_frame(input logic [31:0] word, input int nbits,
                            input int half, input int gap);
    exp_t e;
    spi_cs = 1'b0;
    wait_n(half);
    clock_bits(word, nbits, half);
    if (nbits >= 2) check("busy_in_frame", {31'd0, busy}, 32'd1);
    spi_cs = 1'b1;
    if (nbits == 16) begin
      m_data  = word[11:0];
      m_ctrl  = word[15:12];
      m_count = m_count + 16'd1;
      e.err   = 1'b0;
    end else begin
      e.err   = 1'b1;
    end
    e.data = m_data;
    e.ctrl = m_ctrl;
    e.cnt  = m_count;
    e.cyc  = cyc + 4;
    sb.push_back(e);
    spi_mosi = 1'b0;
    wait_n(gap);
  endtask

  task automatic check_hold(input string name);
    wait_n(10);
    check({name, "_data"}, {20'd0, sample_data}, {20'd0, m_data});
    check({name, "_ctrl"}, {28'd0, sample_ctrl}, {28'd0, m_ctrl});
    check({name, "_count"}, {16'd0, frame_count}, {16'd0, m_count});
    check({name, "_pending"}, sb.size(), 32'd0);
  endtask

  initial begin
    int nb, half, gap, r;
    logic [31:0] w;
    reset    = 1'b1;
    spi_cs   = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    model_reset();
    wait_n(5);
    check("reset_outputs",
          {sample_data, sample_ctrl, sample_valid, frame_error, busy,
           frame_count[12:0]}, 32'd0);
    reset = 1'b0;
    wait_n(6);

    send_frame(32'h3ABC, 16, 4, 6);
    check_hold("basic");

    send_frame(32'h0001, 16, 4, 3);
    send_frame(32'h0FFF, 16, 4, 3);
    send_frame(32'h0800, 16, 4, 3);
    check_hold("b2b");

    send_frame(32'h1234, 15, 4, 6);
    send_frame(32'h1ABCD, 17, 4, 6);
    check_hold("short_long");

    spi_cs = 1'b0;
    wait_n(4);
    clock_bits(32'h00A5, 8, 4);
    reset = 1'b1;
    wait_n(3);
    reset = 1'b0;
    model_reset();
    wait_n(6);
    spi_cs = 1'b1;
    wait_n(8);
    check_hold("abort");
    send_frame(32'h3123, 16, 4, 6);
    check_hold("after_abort");

    reset  = 1'b1;
    spi_cs = 1'b0;
    wait_n(3);
    reset = 1'b0;
    model_reset();
    wait_n(4);
    clock_bits(32'h5A5A, 16, 4);
    check("arm_not_busy", {31'd0, busy}, 32'd0);
    spi_cs = 1'b1;
    wait_n(8);
    check_hold("arm");
    send_frame(32'hC7E1, 16, 3, 5);
    check_hold("after_arm");

    for (int k = 0; k < 60; k++) begin
      r    = $urandom_range(0, 9);
      nb   = (r < 7) ? 16 : (r == 7) ? 15 : (r == 8) ? 17
             : $urandom_range(1, 14);
      w    = $urandom;
      half = $urandom_range(3, 6);
      gap  = $urandom_range(3, 7);
      send_frame(w, nb, half, gap);
    end
    check_hold("random");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
